// File: rtl/race_controller.sv
// Drag-race game-flow sequencer: start countdown, race timer, finish-time latching, end-of-game handshake.
// Optional build macro FALSE_START_EN: a finish edge during the countdown is treated as a false start.
module race_controller #(
  parameter int unsigned TICK_DIV   = 65000,
  parameter int unsigned STEP_MS    = 1000,
  parameter int unsigned TIMEOUT_MS = 60000,
  parameter logic [21:0] TIME_MAX   = 22'h3FFFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_in,
  input  logic        p1_finish,
  input  logic        p2_finish,
  input  logic        key_press_status,
  output logic [1:0]  countdown_lights,
  output logic        race_active,
  output logic        end_game_status,
  output logic [21:0] time_p1,
  output logic [21:0] time_p2,
  output logic [21:0] elapsed_ms
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW = (STEP_MS > 1) ? $clog2(STEP_MS) : 1;
  localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STEP_LAST   = SW'(STEP_MS - 1);
  localparam logic [21:0]   TIMEOUT_LIM = 22'(TIMEOUT_MS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COUNTDOWN = 2'd1,
    RACE      = 2'd2,
    FINISH    = 2'd3
  } state_t;

  state_t         state;
  logic [PW-1:0]  presc;
  logic [SW-1:0]  step_cnt;
  logic           p1_done;
  logic           p2_done;

  logic start_q, start_d;
  logic p1_q, p1_d;
  logic p2_q, p2_d;
  logic key_q;

  logic tick;
  logic start_edge;
  logic p1_hit;
  logic p2_hit;
  logic fs_both;

  // Single input register stage plus one history stage for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_q <= 1'b0;
      start_d <= 1'b0;
      p1_q    <= 1'b0;
      p1_d    <= 1'b0;
      p2_q    <= 1'b0;
      p2_d    <= 1'b0;
      key_q   <= 1'b0;
    end else begin
      start_q <= start_in;
      start_d <= start_q;
      p1_q    <= p1_finish;
      p1_d    <= p1_q;
      p2_q    <= p2_finish;
      p2_d    <= p2_q;
      key_q   <= key_press_status;
    end
  end

  assign tick       = (presc == PRESC_LAST);
  assign start_edge = start_q & ~start_d;
  assign p1_hit     = p1_q & ~p1_d & ~p1_done;
  assign p2_hit     = p2_q & ~p2_d & ~p2_done;

`ifdef FALSE_START_EN
  assign fs_both = (p1_done | p1_hit) & (p2_done | p2_hit);
`else
  assign fs_both = 1'b0;
`endif

  // Prescaler lives here so every state transition can restart it from zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      presc            <= '0;
      step_cnt         <= '0;
      p1_done          <= 1'b0;
      p2_done          <= 1'b0;
      countdown_lights <= 2'd0;
      race_active      <= 1'b0;
      end_game_status  <= 1'b0;
      time_p1          <= '0;
      time_p2          <= '0;
      elapsed_ms       <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      case (state)
        IDLE: begin
          race_active      <= 1'b0;
          end_game_status  <= 1'b0;
          countdown_lights <= 2'd0;
          if (start_edge) begin
            state      <= COUNTDOWN;
            presc      <= '0;
            step_cnt   <= '0;
            p1_done    <= 1'b0;
            p2_done    <= 1'b0;
            time_p1    <= '0;
            time_p2    <= '0;
            elapsed_ms <= '0;
          end
        end

        COUNTDOWN: begin
`ifdef FALSE_START_EN
          if (p1_hit) begin
            time_p1 <= TIME_MAX;
            p1_done <= 1'b1;
          end
          if (p2_hit) begin
            time_p2 <= TIME_MAX;
            p2_done <= 1'b1;
          end
`endif
          if (fs_both) begin
            state            <= FINISH;
            presc            <= '0;
            countdown_lights <= 2'd0;
            race_active      <= 1'b0;
            end_game_status  <= 1'b1;
          end else if (tick) begin
            if (step_cnt == STEP_LAST) begin
              step_cnt         <= '0;
              countdown_lights <= countdown_lights + 1'b1;
              if (countdown_lights == 2'd2) begin
                race_active <= 1'b1;
                state       <= RACE;
                presc       <= '0;
              end
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
        end

        RACE: begin
          if (p1_hit) begin
            time_p1 <= elapsed_ms;
            p1_done <= 1'b1;
          end
          if (p2_hit) begin
            time_p2 <= elapsed_ms;
            p2_done <= 1'b1;
          end
          if (p1_done && p2_done) begin
            state            <= FINISH;
            presc            <= '0;
            race_active      <= 1'b0;
            countdown_lights <= 2'd0;
            end_game_status  <= 1'b1;
          end else if (elapsed_ms >= TIMEOUT_LIM) begin
            // A finish edge landing on the timeout cycle keeps its real time
            if (!p1_done && !p1_hit)
              time_p1 <= TIME_MAX;
            if (!p2_done && !p2_hit)
              time_p2 <= TIME_MAX;
            p1_done          <= 1'b1;
            p2_done          <= 1'b1;
            state            <= FINISH;
            presc            <= '0;
            race_active      <= 1'b0;
            countdown_lights <= 2'd0;
            end_game_status  <= 1'b1;
          end else if (tick && (elapsed_ms != TIME_MAX)) begin
            elapsed_ms <= elapsed_ms + 1'b1;
          end
        end

        FINISH: begin
          race_active      <= 1'b0;
          countdown_lights <= 2'd0;
          end_game_status  <= 1'b1;
          if (key_q) begin
            state           <= IDLE;
            presc           <= '0;
            end_game_status <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_race_controller.sv
// Scoreboard bench for race_controller with a shortened timebase (4 clk per ms, 2 ms steps, 20 ms timeout).
module tb_race_controller;

  localparam int unsigned TD = 4;
  localparam int unsigned SM = 2;
  localparam int unsigned TO = 20;
  localparam logic [21:0] MAXT = 22'h3FFFFF;

  logic        clk;
  logic        reset_n;
  logic        start_in;
  logic        p1_finish;
  logic        p2_finish;
  logic        key_press_status;
  logic [1:0]  countdown_lights;
  logic        race_active;
  logic        end_game_status;
  logic [21:0] time_p1;
  logic [21:0] time_p2;
  logic [21:0] elapsed_ms;

  typedef struct {
    string       name;
    logic [21:0] p1;
    logic [21:0] p2;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  race_controller #(
    .TICK_DIV  (TD),
    .STEP_MS   (SM),
    .TIMEOUT_MS(TO),
    .TIME_MAX  (MAXT)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start_in        (start_in),
    .p1_finish       (p1_finish),
    .p2_finish       (p2_finish),
    .key_press_status(key_press_status),
    .countdown_lights(countdown_lights),
    .race_active     (race_active),
    .end_game_status (end_game_status),
    .time_p1         (time_p1),
    .time_p2         (time_p2),
    .elapsed_ms      (elapsed_ms)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input string name, input logic [21:0] p1, input logic [21:0] p2);
    exp_t e;
    e.name = name;
    e.p1   = p1;
    e.p2   = p2;
    sb.push_back(e);
  endtask

  task automatic wait_elapsed(input logic [21:0] v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (elapsed_ms == v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_race(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (race_active) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_end(output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (end_game_status) begin
        ok = 1'b1;
        cycles = i;
        break;
      end
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    key_press_status = 1'b1;
    repeat (3) @(negedge clk);
    key_press_status = 1'b0;
  endtask

  task automatic start_race();
    @(negedge clk);
    start_in = 1'b1;
    repeat (3) @(negedge clk);
    start_in = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start_in = 1'b0;
    p1_finish = 1'b0;
    p2_finish = 1'b0;
    key_press_status = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({countdown_lights, race_active, end_game_status} !== 4'b0) begin
      bad++;
      $display("[TB] FAIL reset_ctrl got=%b want=0000", {countdown_lights, race_active, end_game_status});
    end
    total++;
    if ({time_p1, time_p2, elapsed_ms} !== 66'd0) begin
      bad++;
      $display("[TB] FAIL reset_times got p1=%0d p2=%0d el=%0d want 0", time_p1, time_p2, elapsed_ms);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_countdown();
    int t_l[4];
    logic race_at3;
    logic race_early;
    t_l = '{default: -1};
    race_at3 = 1'b0;
    race_early = 1'b0;
    @(negedge clk);
    start_in = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 3) start_in = 1'b0;
      if (race_active && countdown_lights != 2'd3) race_early = 1'b1;
      if (t_l[countdown_lights] < 0 && countdown_lights != 2'd0) begin
        t_l[countdown_lights] = i;
        if (countdown_lights == 2'd3) begin
          race_at3 = race_active;
          break;
        end
      end
    end
    total++;
    if (t_l[1] !== 10) begin bad++; $display("[TB] FAIL lights1_cycle got=%0d want=10", t_l[1]); end
    total++;
    if (t_l[2] !== 18) begin bad++; $display("[TB] FAIL lights2_cycle got=%0d want=18", t_l[2]); end
    total++;
    if (t_l[3] !== 26) begin bad++; $display("[TB] FAIL lights3_cycle got=%0d want=26", t_l[3]); end
    total++;
    if (race_at3 !== 1'b1 || race_early !== 1'b0) begin
      bad++;
      $display("[TB] FAIL race_active_at_go got=%b early=%b want=1/0", race_at3, race_early);
    end
  endtask

  task automatic test_two_finish();
    bit ok;
    int cyc;
    exp_t e;
    wait_elapsed(22'd5, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL two_finish_wait5 got=timeout want=elapsed5"); end
    p1_finish = 1'b1;
    push_exp("two_finish", 22'd5, 22'd7);
    wait_elapsed(22'd7, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL two_finish_wait7 got=timeout want=elapsed7"); end
    p2_finish = 1'b1;
    wait_end(ok, cyc);
    total++;
    if (!ok || cyc != 3) begin bad++; $display("[TB] FAIL two_finish_end_latency got=%0d want=3", cyc); end
    e = sb.pop_front();
    total++;
    if (time_p1 !== e.p1 || time_p2 !== e.p2) begin
      bad++;
      $display("[TB] FAIL %s got p1=%0d p2=%0d want p1=%0d p2=%0d", e.name, time_p1, time_p2, e.p1, e.p2);
    end
    p1_finish = 1'b0;
    p2_finish = 1'b0;
  endtask

  task automatic test_restart();
    @(negedge clk);
    total++;
    if (race_active !== 1'b0 || countdown_lights !== 2'd0) begin
      bad++;
      $display("[TB] FAIL finish_outputs got race=%b lights=%0d want 0/0", race_active, countdown_lights);
    end
    key_press_status = 1'b1;
    repeat (2) @(negedge clk);
    key_press_status = 1'b0;
    total++;
    if (end_game_status !== 1'b0 || time_p1 !== 22'd5 || time_p2 !== 22'd7) begin
      bad++;
      $display("[TB] FAIL restart_hold got end=%b p1=%0d p2=%0d want 0/5/7", end_game_status, time_p1, time_p2);
    end
    start_in = 1'b1;
    repeat (2) @(negedge clk);
    start_in = 1'b0;
    total++;
    if (time_p1 !== 22'd0 || time_p2 !== 22'd0 || elapsed_ms !== 22'd0) begin
      bad++;
      $display("[TB] FAIL restart_clear got p1=%0d p2=%0d el=%0d want 0", time_p1, time_p2, elapsed_ms);
    end
  endtask

  task automatic test_same_cycle();
    bit ok;
    int cyc;
    exp_t e;
    wait_race(ok);
    wait_elapsed(22'd9, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL same_cycle_wait9 got=timeout want=elapsed9"); end
    p1_finish = 1'b1;
    p2_finish = 1'b1;
    push_exp("same_cycle", 22'd9, 22'd9);
    wait_end(ok, cyc);
    total++;
    if (!ok || cyc != 3) begin bad++; $display("[TB] FAIL same_cycle_end got=%0d want=3", cyc); end
    e = sb.pop_front();
    total++;
    if (time_p1 !== e.p1 || time_p2 !== e.p2) begin
      bad++;
      $display("[TB] FAIL %s got p1=%0d p2=%0d want p1=%0d p2=%0d", e.name, time_p1, time_p2, e.p1, e.p2);
    end
    p1_finish = 1'b0;
    p2_finish = 1'b0;
    go_idle();
  endtask

  task automatic test_timeout();
    bit ok;
    int cyc;
    exp_t e;
    start_race();
    wait_race(ok);
    wait_elapsed(22'd12, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL timeout_wait12 got=timeout want=elapsed12"); end
    p2_finish = 1'b1;
    push_exp("timeout", MAXT, 22'd12);
    wait_end(ok, cyc);
    e = sb.pop_front();
    total++;
    if (!ok || elapsed_ms !== 22'd20) begin
      bad++;
      $display("[TB] FAIL timeout_elapsed got=%0d ok=%b want=20", elapsed_ms, ok);
    end
    total++;
    if (time_p1 !== e.p1 || time_p2 !== e.p2) begin
      bad++;
      $display("[TB] FAIL %s got p1=%0h p2=%0d want p1=%0h p2=%0d", e.name, time_p1, time_p2, e.p1, e.p2);
    end
    p2_finish = 1'b0;
    go_idle();
  endtask

  task automatic test_false_start();
    bit ok;
    int cyc;
    exp_t e;
    ok = 1'b0;
    @(negedge clk);
    start_in = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 2) start_in = 1'b0;
      if (countdown_lights == 2'd1) begin
        ok = 1'b1;
        break;
      end
    end
    start_in = 1'b0;
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL false_start_lights1 got=timeout want=lights1"); end
    p1_finish = 1'b1;
    repeat (3) @(negedge clk);
    p1_finish = 1'b0;
`ifdef FALSE_START_EN
    total++;
    if (time_p1 !== MAXT || race_active !== 1'b0) begin
      bad++;
      $display("[TB] FAIL false_start_mark got p1=%0h race=%b want %0h/0", time_p1, race_active, MAXT);
    end
    push_exp("false_start", MAXT, 22'd6);
    wait_race(ok);
    wait_elapsed(22'd6, ok);
    p2_finish = 1'b1;
`else
    push_exp("false_start", 22'd10, 22'd6);
    wait_race(ok);
    wait_elapsed(22'd6, ok);
    p2_finish = 1'b1;
    wait_elapsed(22'd10, ok);
    p1_finish = 1'b1;
`endif
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL false_start_race got=timeout want=race_progress"); end
    wait_end(ok, cyc);
    e = sb.pop_front();
    total++;
    if (!ok || time_p1 !== e.p1 || time_p2 !== e.p2) begin
      bad++;
      $display("[TB] FAIL %s got p1=%0h p2=%0d want p1=%0h p2=%0d", e.name, time_p1, time_p2, e.p1, e.p2);
    end
    p1_finish = 1'b0;
    p2_finish = 1'b0;
    go_idle();
  endtask

  task automatic test_reset_mid_race();
    bit ok;
    start_race();
    wait_race(ok);
    wait_elapsed(22'd3, ok);
    total++;
    if (!ok || race_active !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midrace_setup got ok=%b race=%b want 1/1", ok, race_active);
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if ({countdown_lights, race_active, end_game_status} !== 4'b0 || elapsed_ms !== 22'd0 ||
        time_p1 !== 22'd0 || time_p2 !== 22'd0) begin
      bad++;
      $display("[TB] FAIL midrace_reset got lights=%0d race=%b end=%b el=%0d want all 0",
               countdown_lights, race_active, end_game_status, elapsed_ms);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_two_finish();
    test_restart();
    test_same_cycle();
    test_timeout();
    test_false_start();
    test_reset_mid_race();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_left got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got=hang want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/race_controller.md
Name: race_controller

Overview:
Game-flow sequencer for Drag-Racing. Runs the start countdown and the race timer, latches each player's finish time, and raises end_game_status. It drives the time_p1, time_p2 and end_game_status inputs of the scoreboard. It consumes the scoreboard's key_press_status to return to idle for the next race.

Parameters:
TICK_DIV, 65000, clk cycles per 1 ms timer tick (65 MHz pixel clock).
STEP_MS, 1000, duration of each countdown step in ms.
TIMEOUT_MS, 60000, race timeout in ms.
TIME_MAX, 22'h3FFFFF, saturation value and "did not finish / false start" time.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start_in  in  1  start request from keyboard decoder (level; rising edge used)
p1_finish  in  1  player 1 crossed finish line (level; rising edge used)
p2_finish  in  1  player 2 crossed finish line (level; rising edge used)
key_press_status  in  1  restart acknowledge from scoreboard
countdown_lights  out  2  number of lit lights, 0..3; 3 means GO
race_active  out  1  high while RACE state
end_game_status  out  1  high while FINISH state
time_p1  out  22  player 1 time in ms
time_p2  out  22  player 2 time in ms
elapsed_ms  out  22  running race time in ms

Behaviour:
- All flops reset asynchronously on reset_n low.
- Reset values: outputs 0, state IDLE, prescaler 0, edge-detect history 0.
- Inputs are registered once. Edge is defined as registered value 1 and previous value 0, so an event is acted on 2 cycles after the input rises.
- Prescaler counts 0..TICK_DIV-1. tick is asserted for one cycle at wrap. The prescaler is cleared on every state entry.
- FSM states: IDLE, COUNTDOWN, RACE, FINISH.
- IDLE:
  - start edge -> COUNTDOWN, with countdown_lights=0, step counter=0, time_p1=time_p2=elapsed_ms=0.
  - Finish edges are ignored.
- COUNTDOWN:
  - The step counter counts ticks. At STEP_MS ticks it resets and countdown_lights increments.
  - When lights goes 2->3: race_active=1 and the FSM goes to RACE in the same cycle.
  - start edges are ignored.
- RACE:
  - elapsed_ms increments on each tick, saturating at TIME_MAX.
  - p1 finish edge while p1 not yet done: time_p1 <= elapsed_ms (value before this cycle's increment) and p1 done flag is set. p2 is handled identically.
  - Both edges in the same cycle: both latch the same value.
  - Further edges from a done player are ignored.
  - Both done -> FINISH on the next cycle.
  - elapsed_ms reaching TIMEOUT_MS: every not-done player's time <= TIME_MAX, then -> FINISH.
  - A finish edge coinciding with the timeout cycle wins, i.e. the real time is latched.
- FINISH:
  - end_game_status=1, race_active=0, countdown_lights=0.
  - Times are held stable.
  - key_press_status=1 -> IDLE; end_game_status drops the next cycle, and the scoreboard clears its flag.
  - Times are held in IDLE until the next start.
- Equal times are legal. The scoreboard shows no winner; the controller takes no special action.
- reset_n asserted in any state returns to IDLE immediately with all outputs 0.

Optional Feature:
Macro FALSE_START_EN.
- Defined: a player finish edge during COUNTDOWN is treated as a false start.
  - That player's time <= TIME_MAX and the player is marked done.
  - The countdown continues.
  - If both players false-start, the FSM goes COUNTDOWN -> FINISH directly when the second one occurs.
- Not defined: finish edges during COUNTDOWN are ignored, and both players always race.

Test Plan:
1. TICK_DIV=4, STEP_MS=2: reset, pulse start_in -> countdown_lights steps 0,1,2,3 every 8 clk; race_active rises with lights=3.
2. In RACE, p1_finish at elapsed_ms=5 and p2_finish at 7 -> time_p1=5, time_p2=7; end_game_status=1 one cycle after the second latch.
3. p1_finish and p2_finish rise in the same cycle at elapsed_ms=9 -> time_p1=time_p2=9; FINISH entered.
4. TIMEOUT_MS=20, only p2 finishes at 12 -> at elapsed_ms=20, time_p1=22'h3FFFFF, time_p2=12; FINISH.
5. In FINISH, pulse key_press_status -> IDLE with end_game_status=0 and times held. A second start_in clears the times to 0.
6. FALSE_START_EN defined, p1_finish during lights=1 -> time_p1=22'h3FFFFF; p2 races normally. Separately, reset_n low mid-RACE -> all outputs 0 asynchronously.
